// File: rtl/count_pkg.sv
// count_pkg: FSM state encodings and mode constants shared by the counter enable path
package count_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;
endpackage

// File: rtl/count_enable_gen_tick_divider.sv
// tick_divider: programmable prescaler, ticks once every div+1 running cycles
module tick_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  always_comb begin
    tick_o = run_i && (cnt_q == div_q);
    div_d  = load_i ? div_i : div_q;
    // Counter returns to 0 on the tick, so it never exceeds div_q and never wraps
    cnt_d  = (load_i || tick_o) ? '0 : run_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/count_enable_gen.sv
// count_enable_gen: prescaled enable pulses for up_counter, continuous or N-pulse burst
module count_enable_gen
  import count_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               enable_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [BURST_W-1:0] pulses_left_o
);
  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [BURST_W-1:0] left_q, left_d;
  logic               accept, tick, last;
  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .load_i  (accept),
    .run_i   (state_q == RUN),
    .div_i   (div_i),
    .tick_o  (tick)
  );
  always_comb begin
    accept        = (state_q == IDLE) && start_i && !stop_i;
    last          = tick && (mode_q == MODE_BURST) && (left_q == BURST_W'(1));
    enable_o      = tick;
    busy_o        = (state_q == RUN);
    done_o        = (state_q == DONE);
    pulses_left_o = left_q;
    mode_d        = accept ? mode_i : mode_q;
    state_d       = state_q;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE :
                         (mode_i == MODE_BURST && burst_len_i == '0) ? DONE : RUN;
      RUN:     state_d = stop_i ? IDLE : last ? DONE : RUN;
      default: state_d = IDLE;
    endcase
    // Remaining count is only meaningful in a running burst; it reads 0 everywhere else
    left_d = accept ? ((mode_i == MODE_BURST) ? burst_len_i : '0) :
             (state_q != RUN || stop_i) ? '0 :
             (tick && mode_q == MODE_BURST) ? left_q - 1'b1 : left_q;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      mode_q  <= MODE_CONT;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      left_q  <= left_d;
    end
  end
endmodule

// File: tb/tb_count_enable_gen.sv
// tb_count_enable_gen: directed and random stimulus against a cycle-arithmetic model
module tb_count_enable_gen;
  logic       clk = 1'b0;
  logic       reset_ni, start, stop, mode;
  logic [7:0] div;
  logic [3:0] len;
  logic       enable_o, busy_o, done_o;
  logic [3:0] pulses_left_o;
  int total = 0, passed = 0, cyc = 0, en_cnt = 0, dn_cnt = 0;
  bit m_valid = 0, m_active = 0, m_mode = 0;
  int m_t0 = 0, m_D = 0, m_N = 0, m_issued = 0, m_done_at = -1;

  count_enable_gen #(.DIV_W(8), .BURST_W(4)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start), .stop_i(stop), .mode_i(mode),
    .div_i(div), .burst_len_i(len), .enable_o(enable_o), .busy_o(busy_o),
    .done_o(done_o), .pulses_left_o(pulses_left_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d, want %0d", n, cyc, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: enables land on every (D+1)-th cycle after the start cycle; burst ends after N of them
  always @(negedge clk) begin
    bit e_en;
    int e_pl;
    e_en = m_active && ((cyc - m_t0) % (m_D + 1) == 0);
    e_pl = (m_active && m_mode) ? m_N - m_issued : 0;
    if (m_valid) begin
      chk("enable", enable_o, e_en);
      chk("busy", busy_o, m_active);
      chk("done", done_o, cyc == m_done_at);
      chk("pulses_left", pulses_left_o, e_pl);
    end
    if (enable_o === 1'b1) en_cnt++;
    if (done_o === 1'b1) dn_cnt++;
    if (!reset_ni) begin
      m_valid = 1; m_active = 0; m_done_at = -1;
    end else if (m_active) begin
      if (e_en) m_issued++;
      if (stop) m_active = 0;
      else if (m_mode && m_issued == m_N) begin
        m_active = 0; m_done_at = cyc + 1;
      end
    end else if (cyc != m_done_at && start && !stop) begin
      m_mode = mode; m_D = div; m_N = len; m_issued = 0;
      if (mode && len == 0) m_done_at = cyc + 1;
      else begin m_active = 1; m_t0 = cyc; end
    end
    cyc++;
  end

  initial begin
    int b, d;
    reset_ni = 0; start = 1; stop = 0; mode = 0; div = 0; len = 0;
    repeat (3) begin
      step();
      chk("rst_enable", enable_o, 0); chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0); chk("rst_left", pulses_left_o, 0);
    end
    reset_ni = 1; start = 0;
    step();
    chk("post_rst_busy", busy_o, 0); chk("post_rst_enable", enable_o, 0);
    // Continuous, div=0, stopped during the 10th pulse
    mode = 0; div = 0; start = 1;
    step(); start = 0; b = en_cnt; d = dn_cnt;
    chk("cont_first_enable", enable_o, 1);
    repeat (9) step();
    stop = 1;
    step(); stop = 0;
    chk("cont_busy_after_stop", busy_o, 0); chk("cont_enable_after_stop", enable_o, 0);
    chk("cont_pulse_count", en_cnt - b, 10); chk("cont_done_count", dn_cnt - d, 0);
    // Burst div=2 len=5; inputs changed after start must not matter
    mode = 1; div = 2; len = 5; start = 1;
    step(); start = 0; mode = 0; div = 7; len = 9; b = en_cnt; d = dn_cnt;
    for (int j = 1; j <= 16; j++) begin
      chk("burst_enable", enable_o, (j % 3 == 0) && j <= 15);
      chk("burst_done", done_o, j == 16);
      chk("burst_busy", busy_o, j < 16);
      chk("burst_left", pulses_left_o, j < 16 ? 5 - (j - 1) / 3 : 0);
      start = (j == 8);
      step();
    end
    start = 0;
    chk("burst_counter_advance", en_cnt - b, 5); chk("burst_done_count", dn_cnt - d, 1);
    // Zero-length burst
    mode = 1; len = 0; start = 1;
    step(); start = 0;
    chk("zero_done", done_o, 1); chk("zero_enable", enable_o, 0); chk("zero_busy", busy_o, 0);
    step();
    chk("zero_done_once", done_o, 0);
    // Stop on 3rd of 4 pulses, div=1
    mode = 1; div = 1; len = 4; start = 1;
    step(); start = 0; b = en_cnt; d = dn_cnt;
    repeat (5) step();
    chk("stop_third_enable", enable_o, 1);
    stop = 1;
    step(); stop = 0;
    repeat (4) step();
    chk("stop_pulse_count", en_cnt - b, 3); chk("stop_done_count", dn_cnt - d, 0);
    chk("stop_busy", busy_o, 0);
    start = 1; stop = 1;
    step(); start = 0; stop = 0;
    chk("start_stop_idle", busy_o, 0); chk("start_stop_done", done_o, 0);
    // Reset mid-burst at pulses_left=3, then a clean 2-pulse burst
    mode = 1; div = 0; len = 5; start = 1;
    step(); start = 0;
    step(); step();
    chk("mid_left", pulses_left_o, 3);
    reset_ni = 0;
    step();
    chk("mid_rst_enable", enable_o, 0); chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0); chk("mid_rst_left", pulses_left_o, 0);
    reset_ni = 1; mode = 1; div = 1; len = 2; start = 1;
    step(); start = 0; b = en_cnt; d = dn_cnt;
    repeat (6) step();
    chk("rerun_pulses", en_cnt - b, 2); chk("rerun_done", dn_cnt - d, 1);
    // Random traffic
    repeat (4000) begin
      reset_ni = $urandom_range(0, 79) != 0;
      start = $urandom_range(0, 5) == 0;
      stop = $urandom_range(0, 29) == 0;
      mode = 1'($urandom_range(0, 1));
      div = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      len = 4'($urandom_range(0, 15));
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
